// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the multi-cycle MIPS-subset core.
// Holds the opcode map, FSM state encoding, ALU operation encoding and
// the ALU helper used by the EXEC state.
package cpu_pkg;

    // Opcodes, instruction bits [31:26]
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_OR   = 6'b010010;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // FSM state encoding
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    // ALU operation encoding
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

    // 32-bit wrap-around ALU; no overflow detection
    function automatic logic [31:0] alu_compute(input logic [1:0] op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            default: r = a + b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mc_register_file.sv
// mc_register_file: REG_NUM x 32-bit register file with two asynchronous
// read ports and one synchronous write port. Register 0 always reads zero
// and ignores writes. All registers clear on synchronous reset.
module mc_register_file #(
    parameter int REG_NUM = 32,
    parameter int IDX_W   = $clog2(REG_NUM)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] ra1,
    input  logic [IDX_W-1:0] ra2,
    output logic [31:0]      rd1,
    output logic [31:0]      rd2,
    input  logic             we,
    input  logic [IDX_W-1:0] wa,
    input  logic [31:0]      wd
);

    logic [31:0] regs [REG_NUM];

    // Synchronous clear on reset, otherwise single write port (reg 0 protected)
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    // Asynchronous reads, reg 0 forced to zero
    always_comb begin
        rd1 = (ra1 == '0) ? 32'h0 : regs[ra1];
        rd2 = (ra2 == '0) ? 32'h0 : regs[ra2];
    end

endmodule

// File: rtl/multi_cycle_cpu_core.sv
// multi_cycle_cpu_core: multi-cycle MIPS-subset core
// (FETCH/DECODE/EXEC/MEM/WB/HALT) with request/ready memory handshakes.
// Optional macro CPU_PERF_COUNTERS_EN adds cycle_count/retired_count outputs.
//
// Handshake: a request (imem_req/dmem_req) is a decode of registered state
// and holds, with stable address/data, until the matching ready is seen
// high in a cycle where the request is high; the transfer completes on that
// rising edge. ready while no request is pending is ignored.
module multi_cycle_cpu_core
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                REG_NUM  = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ready,
    output logic [ADDR_W-1:0] pc,
`ifdef CPU_PERF_COUNTERS_EN
    output logic [31:0]       cycle_count,
    output logic [31:0]       retired_count,
`endif
    output logic              halted,
    output logic              illegal,
    output logic [2:0]        fsm_state
);

    localparam int IDX_W = $clog2(REG_NUM);

    logic [2:0]        state;
    logic [31:0]       ir;
    logic [31:0]       a_reg;
    logic [31:0]       b_reg;
    logic [31:0]       imm_reg;
    logic [31:0]       alu_out;
    logic [31:0]       mdr;
    logic              illegal_r;
    logic              req_en;

    logic [5:0]        op;
    logic [4:0]        rs_f, rt_f, rd_f;
    logic [IDX_W-1:0]  rs_idx, rt_idx, rd_idx;
    logic              is_rtype, is_known;
    logic [31:0]       imm_ext;
    logic [1:0]        alu_op;
    logic [31:0]       alu_b;
    logic [31:0]       alu_result;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] imm_addr;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] jump_target;
    logic [31:0]       rf_rd1, rf_rd2;
    logic              rf_we;
    logic [IDX_W-1:0]  rf_wa;
    logic [31:0]       rf_wd;
    logic              retire;

    // Instruction field decode and datapath arithmetic
    always_comb begin
        op       = ir[31:26];
        rs_f     = ir[25:21];
        rt_f     = ir[20:16];
        rd_f     = ir[15:11];
        rs_idx   = rs_f[IDX_W-1:0];
        rt_idx   = rt_f[IDX_W-1:0];
        rd_idx   = rd_f[IDX_W-1:0];
        is_rtype = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
        is_known = is_rtype || (op == OP_ADDI) || (op == OP_ORI) || (op == OP_SW) ||
                   (op == OP_LW) || (op == OP_BEQ) || (op == OP_J) || (op == OP_HALT);
        imm_ext  = (op == OP_ORI) ? {16'h0, ir[15:0]} : {{16{ir[15]}}, ir[15:0]};
        case (op)
            OP_SUB:         alu_op = ALU_SUB;
            OP_AND:         alu_op = ALU_AND;
            OP_OR, OP_ORI:  alu_op = ALU_OR;
            default:        alu_op = ALU_ADD;
        endcase
        alu_b       = is_rtype ? b_reg : imm_reg;
        alu_result  = alu_compute(alu_op, a_reg, alu_b);
        pc_plus4    = pc + ADDR_W'(4);
        imm_addr    = ADDR_W'(imm_reg);
        br_target   = pc_plus4 + (imm_addr << 2);
        // Upper PC bits above the 28-bit jump region come from pc+4
        jump_target = (pc_plus4 & ~ADDR_W'(32'h0FFF_FFFF)) | ADDR_W'({ir[25:0], 2'b00});
        rf_we       = (state == ST_WB);
        rf_wa       = is_rtype ? rd_idx : rt_idx;
        rf_wd       = (op == OP_LW) ? mdr : alu_out;
        retire      = (state == ST_WB) ||
                      ((state == ST_EXEC) && ((op == OP_BEQ) || (op == OP_J))) ||
                      ((state == ST_MEM) && dmem_ready && (op == OP_SW));
    end

    mc_register_file #(
        .REG_NUM (REG_NUM),
        .IDX_W   (IDX_W)
    ) u_rf (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs_idx),
        .ra2   (rt_idx),
        .rd1   (rf_rd1),
        .rd2   (rf_rd2),
        .we    (rf_we),
        .wa    (rf_wa),
        .wd    (rf_wd)
    );

    // Moore outputs; req_en keeps requests low for the cycle after reset
    always_comb begin
        imem_req   = (state == ST_FETCH) && req_en;
        imem_addr  = pc;
        dmem_req   = (state == ST_MEM);
        dmem_we    = (state == ST_MEM) && (op == OP_SW);
        dmem_addr  = ADDR_W'(alu_out);
        dmem_wdata = b_reg;
        halted     = (state == ST_HALT);
        illegal    = illegal_r;
        fsm_state  = state;
    end

    // Main FSM and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_FETCH;
            pc        <= PC_RESET;
            ir        <= 32'h0;
            a_reg     <= 32'h0;
            b_reg     <= 32'h0;
            imm_reg   <= 32'h0;
            alu_out   <= 32'h0;
            mdr       <= 32'h0;
            illegal_r <= 1'b0;
            req_en    <= 1'b0;
        end else begin
            req_en <= 1'b1;
            case (state)
                ST_FETCH: begin
                    if (imem_req && imem_ready) begin
                        ir    <= imem_rdata;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    a_reg   <= rf_rd1;
                    b_reg   <= rf_rd2;
                    imm_reg <= imm_ext;
                    if (op == OP_HALT) begin
                        state <= ST_HALT;
                    end else if (!is_known) begin
                        state     <= ST_HALT;
                        illegal_r <= 1'b1;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    alu_out <= alu_result;
                    if (op == OP_BEQ) begin
                        pc    <= (a_reg == b_reg) ? br_target : pc_plus4;
                        state <= ST_FETCH;
                    end else if (op == OP_J) begin
                        pc    <= jump_target;
                        state <= ST_FETCH;
                    end else if ((op == OP_LW) || (op == OP_SW)) begin
                        state <= ST_MEM;
                    end else begin
                        state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        if (op == OP_SW) begin
                            pc    <= pc_plus4;
                            state <= ST_FETCH;
                        end else begin
                            mdr   <= dmem_rdata;
                            state <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    pc    <= pc_plus4;
                    state <= ST_FETCH;
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_HALT;
                end
            endcase
        end
    end

`ifdef CPU_PERF_COUNTERS_EN
    // Free-running cycle and retired-instruction counters, wrap at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count   <= 32'h0;
            retired_count <= 32'h0;
        end else begin
            if (state != ST_HALT) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if (retire) begin
                retired_count <= retired_count + 32'd1;
            end
        end
    end
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: doc/multi_cycle_cpu_core.md
Name: multi_cycle_cpu_core

Overview:
- Parametrised multi-cycle MIPS-subset core; successor to the team's single-cycle CPU.
- Executes each instruction over several FSM states (FETCH/DECODE/EXEC/MEM/WB).
- Talks to external instruction and data memories through request/ready handshakes, so memories may add wait states.
- Adds reset, a configurable reset PC, a configurable register count, a jump instruction and halt/illegal reporting.

Parameters:
- REG_NUM, 32, number of architectural registers (power of two, 8..32); register 0 is hard-wired zero.
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, width of PC and memory address buses.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  fetch address (= pc).
- imem_rdata  in  32  instruction word.
- imem_ready  in  1  fetch complete; imem_rdata valid this cycle.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  ADDR_W  data address (ALU result).
- dmem_wdata  out  32  store data (rt value).
- dmem_rdata  in  32  load data.
- dmem_ready  in  1  data access complete; dmem_rdata valid this cycle.
- pc  out  ADDR_W  current PC.
- halted  out  1  core in HALT state.
- illegal  out  1  sticky; halted on an unknown opcode.

Behaviour:
- Reset (synchronous, active-high): pc=PC_RESET, state=FETCH, all registers 0, IR=0, halted=0, illegal=0. imem_req/dmem_req/dmem_we are 0 for the cycle after the reset edge, then FETCH asserts imem_req. Reset mid-handshake abandons the transaction; no register or PC write from it.
- Opcodes [31:26]:
  - add 000000, addi 000001, sub 000010
  - ori 010000, and 010001, or 010010
  - sw 100110, lw 100111, beq 110000
  - j 111000, halt 111111
  - Fields: rs[25:21], rt[20:16], rd[15:11], imm[15:0], target[25:0].
- Extension: addi/lw/sw/beq sign-extend imm; ori zero-extends. 32-bit wrap-around arithmetic, no overflow trap.
- Register indexing: index bits above log2(REG_NUM) are ignored. Reads of reg 0 return 0; writes to reg 0 are discarded.
- FSM:
  - FETCH: imem_req=1, imem_addr=pc; hold until imem_ready. On imem_ready, latch IR and go to DECODE.
  - DECODE: read rs/rt into A/B, build immediate. halt -> HALT; unknown opcode -> HALT with illegal=1; else -> EXEC.
  - EXEC:
    - ALU result latched.
    - beq: pc <= pc+4+(simm<<2) if A==B, else pc+4; -> FETCH.
    - j: pc <= {pc_plus4[ADDR_W-1:28], target, 2'b00}; -> FETCH.
    - lw/sw -> MEM; arithmetic -> WB.
  - MEM: dmem_req=1, dmem_we=(sw), dmem_addr=A+simm; hold until dmem_ready. sw: pc<=pc+4, -> FETCH. lw: latch MDR, -> WB.
  - WB: R-type writes rd; addi/ori write rt; lw writes rt with MDR. pc<=pc+4; -> FETCH.
  - HALT: terminal; all requests 0, pc frozen; exits only via reset.
- Latency with zero-wait memories (ready in same cycle as req):
  - add/sub/and/or/addi/ori 4 cycles; lw 5; sw 4; beq/j 3.
  - Each wait cycle on a ready line adds 1.
- Request outputs are registered-state decodes (Moore); address/data stable while req is high.
- ready outside a request is ignored.

Optional Feature:
- Macro CPU_PERF_COUNTERS_EN.
- Defined: adds outputs cycle_count[31:0] (increments every non-reset cycle while not halted) and retired_count[31:0] (increments on each instruction's final state, i.e. FETCH entry after EXEC/MEM/WB; halt not counted). Both clear on reset and wrap at 2^32.
- Undefined: ports and logic absent; core behaviour otherwise identical.

Decomposition:
- Package cpu_pkg:
  - opcode localparams
  - FSM state encoding: FETCH, DECODE, EXEC, MEM, WB, HALT
  - ALU op encoding: ADD, SUB, AND, OR
- Sub-module mc_register_file: REG_NUM parameter, two async read ports, one sync write port, synchronous clear on reset, reg 0 forced to zero.

Test Plan:
- Reset then addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2 with zero-wait memories -> reg3=2, pc=12 after 12 cycles.
- sw $1,8($0) then lw $4,8($0) with dmem_ready delayed 2 cycles each -> store addr 8 data 5; reg4=5; lw takes 7 cycles.
- beq $1,$1,-1 taken (loop) -> pc returns to its own address each 3 cycles; not-taken case with unequal regs -> pc+4.
- ori $5,$0,0xFFFF -> reg5=32'h0000FFFF; addi $5,$0,0xFFFF -> 32'hFFFFFFFF; addi $0,$0,7 -> reg0 stays 0.
- Opcode 101010 -> halted=1, illegal=1 after DECODE, no further imem_req. halt -> halted=1, illegal=0. reset -> both clear, fetch at PC_RESET.
- Assert reset while MEM waits on dmem_ready for a sw -> dmem_req drops next cycle, no write, pc=PC_RESET; with CPU_PERF_COUNTERS_EN, counters read 0.
